// File: rtl/sram_port_arbiter_if.sv
// Bundle between the word requesters and the arbiter, plus the external SRAM strobes/address.
// The 16-bit data bus stays a plain inout on the arbiter so tristate resolution stays simple.
interface sram_port_arbiter_if #(
    parameter int unsigned NumPorts = 2,
    parameter int unsigned AddrW    = 23
);
    localparam int unsigned IdW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    logic [NumPorts-1:0]           req;
    logic [NumPorts-1:0]           wr;
    logic [NumPorts*(AddrW-1)-1:0] addr;
    logic [NumPorts*32-1:0]        wdata;
    logic [31:0]                   rdata;
    logic [NumPorts-1:0]           done;
    logic [IdW-1:0]                grant_id;
    logic                          busy;
    logic [AddrW-1:0]              addr2sram;
    logic                          cs;
    logic                          we;
    logic                          oe;
    logic                          ub;
    logic                          lb;

    // Requester/SRAM-model side.
    modport master (
        output req, wr, addr, wdata,
        input  rdata, done, grant_id, busy, addr2sram, cs, we, oe, ub, lb
    );

    // Arbiter side.
    modport slave (
        input  req, wr, addr, wdata,
        output rdata, done, grant_id, busy, addr2sram, cs, we, oe, ub, lb
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter mapping NumPorts 32-bit word requesters onto a 16-bit async SRAM bus.
// Each word is two halfword accesses (low first) with WaitCycles-long strobes and a recovery cycle.
module sram_port_arbiter #(
    parameter int unsigned       NumPorts   = 2,
    parameter int unsigned       AddrW      = 23,
    parameter int unsigned       WaitCycles = 4,
    parameter logic [AddrW-1:0]  BaseHalf   = '0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    sram_port_arbiter_if.slave bus,
    inout  wire  [15:0]        data_sram_io
);
    localparam int unsigned IdW  = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int unsigned CntW = (WaitCycles > 1) ? $clog2(WaitCycles) : 1;

    typedef enum logic [2:0] {StIdle, StAccLo, StRecLo, StAccHi, StRecHi, StDone} state_e;

    state_e              state_q;
    logic [CntW-1:0]     cnt_q;
    logic [IdW-1:0]      grant_q;
    logic                wr_q;
    logic [AddrW-2:0]    addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic [NumPorts-1:0] done_q;
    logic [AddrW-1:0]    addr2sram_q;
    logic                cs_q, we_q, oe_q, ub_q, lb_q;
    logic                drive_q;
    logic [15:0]         dout_q;

    logic [AddrW-2:0]    addr_a  [NumPorts];
    logic [31:0]         wdata_a [NumPorts];
    logic                pick_valid;
    logic [IdW-1:0]      pick_id;

    for (genvar p = 0; p < NumPorts; p++) begin : g_unpack
        assign addr_a[p]  = bus.addr[p*(AddrW-1) +: AddrW-1];
        assign wdata_a[p] = bus.wdata[p*32 +: 32];
    end

    // Rank 0 is the port just after the last grant; lowest-ranked requester wins.
    always_comb begin
        int unsigned rank;
        int unsigned best;
        pick_valid = 1'b0;
        pick_id    = '0;
        rank       = 0;
        best       = NumPorts;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            rank = (p + NumPorts - 1 - 32'(grant_q)) % NumPorts;
            if (bus.req[IdW'(p)] && rank < best) begin
                best       = rank;
                pick_valid = 1'b1;
                pick_id    = IdW'(p);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            grant_q     <= IdW'(NumPorts - 1);
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            done_q      <= '0;
            addr2sram_q <= '0;
            {cs_q, we_q, oe_q, ub_q, lb_q} <= 5'b11111;
            drive_q     <= 1'b0;
            dout_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        state_q     <= StAccLo;
                        grant_q     <= pick_id;
                        wr_q        <= bus.wr[pick_id];
                        addr_q      <= addr_a[pick_id];
                        wdata_q     <= wdata_a[pick_id];
                        cnt_q       <= '0;
                        addr2sram_q <= {addr_a[pick_id], 1'b0} + BaseHalf;
                        {cs_q, ub_q, lb_q} <= 3'b000;
                        oe_q        <= bus.wr[pick_id];
                        we_q        <= ~bus.wr[pick_id];
                        drive_q     <= bus.wr[pick_id];
                        dout_q      <= wdata_a[pick_id][15:0];
                    end
                end
                StAccLo: begin
                    if (cnt_q == CntW'(WaitCycles - 1)) begin
                        if (!wr_q) rdata_q[15:0] <= data_sram_io;
                        state_q <= StRecLo;
                        {cs_q, we_q, oe_q, ub_q, lb_q} <= 5'b11111;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StRecLo: begin
                    state_q     <= StAccHi;
                    cnt_q       <= '0;
                    addr2sram_q <= {addr_q, 1'b1} + BaseHalf;
                    {cs_q, ub_q, lb_q} <= 3'b000;
                    oe_q        <= wr_q;
                    we_q        <= ~wr_q;
                    dout_q      <= wdata_q[31:16];
                end
                StAccHi: begin
                    if (cnt_q == CntW'(WaitCycles - 1)) begin
                        if (!wr_q) rdata_q[31:16] <= data_sram_io;
                        state_q <= StRecHi;
                        {cs_q, we_q, oe_q, ub_q, lb_q} <= 5'b11111;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StRecHi: begin
                    state_q          <= StDone;
                    drive_q          <= 1'b0;
                    done_q[grant_q]  <= 1'b1;
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= '0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign data_sram_io  = drive_q ? dout_q : 16'hzzzz;
    assign bus.rdata     = rdata_q;
    assign bus.done      = done_q;
    assign bus.grant_id  = grant_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.addr2sram = addr2sram_q;
    assign bus.cs        = cs_q;
    assign bus.we        = we_q;
    assign bus.oe        = oe_q;
    assign bus.ub        = ub_q;
    assign bus.lb        = lb_q;
endmodule
